shift_register_ctrl: RTL

Frame controller that sequences the 8-bit `shift_register` as a parallel-to-serial transmitter. Accepts one parallel word per valid/ready handshake, issues the load pulse, tracks the shift-out of every bit, and qualifies the serial stream with a bit-valid strobe. Sits between a byte-producing master and the `shift_register` instance; both blocks share one clock and reset domain.

---
 rtl/shift_ctrl_pkg.sv | 16 +
 rtl/shift_register_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift_register frame controller:
// state encoding and default word width.
package shift_ctrl_pkg;

  localparam int DATA_W_DEF = 8;

  // Frame sequencing states; PARITY is only reachable when
  // SHIFT_CTRL_PARITY_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    PARITY = 2'd3
  } state_t;

endpackage : shift_ctrl_pkg

// File: rtl/shift_register_ctrl.sv
// Parallel-to-serial frame controller for an external DATA_W-bit
// shift_register. Accepts a word on valid/ready, pulses the load,
// counts the shifted bits and qualifies the serial stream.
// Optional feature macro: SHIFT_CTRL_PARITY_EN appends one even-parity
// bit after the LSB and moves o_done onto that bit.
module shift_register_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_load,
  output logic [DATA_W-1:0] o_par_in,
  output logic              o_ser_in,
  input  logic              i_ser_out,
  output logic              o_tx,
  output logic              o_tx_en,
  output logic              o_busy,
  output logic              o_done
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_par_in;
  logic                w_accept;
  logic                w_ready;
  logic                w_load;
  logic                w_tx;
  logic                w_tx_en;
  logic                w_done;

  // Even parity: the appended bit makes the total count of ones even.
  function automatic logic f_even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign w_accept = (r_state == IDLE) && i_valid;

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Bit counter: cleared while loading, advances once per shifted bit.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (r_state == LOAD) begin
      r_cnt <= '0;
    end else if ((r_state == SHIFT) && (r_cnt != CNT_LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Word holding register: captured on acceptance, stable until the next one.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_par_in <= '0;
    end else if (w_accept) begin
      r_par_in <= i_data;
    end else begin
      r_par_in <= r_par_in;
    end
  end

  // Next-state and state-decoded outputs; the serial bit is the
  // shift_register MSB while shifting and the parity bit afterwards.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_load       = 1'b0;
    w_tx         = 1'b0;
    w_tx_en      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (i_valid) begin
          w_next_state = LOAD;
        end else begin
          w_next_state = IDLE;
        end
      end
      LOAD: begin
        w_load       = 1'b1;
        w_next_state = SHIFT;
      end
      SHIFT: begin
        w_tx    = i_ser_out;
        w_tx_en = 1'b1;
        if (r_cnt == CNT_LAST) begin
`ifdef SHIFT_CTRL_PARITY_EN
          w_next_state = PARITY;
`else
          w_next_state = IDLE;
          w_done       = 1'b1;
`endif
        end else begin
          w_next_state = SHIFT;
        end
      end
`ifdef SHIFT_CTRL_PARITY_EN
      PARITY: begin
        w_tx         = f_even_parity(r_par_in);
        w_tx_en      = 1'b1;
        w_done       = 1'b1;
        w_next_state = IDLE;
      end
`endif
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign o_ready  = w_ready;
  assign o_load   = w_load;
  assign o_par_in = r_par_in;
  assign o_ser_in = 1'b0;
  assign o_tx     = w_tx;
  assign o_tx_en  = w_tx_en;
  assign o_busy   = (r_state != IDLE);
  assign o_done   = w_done;

endmodule : shift_register_ctrl
